ysyx_23060208_clint: RTL and testbench

- Core-local interruptor (CLINT) as an AXI4 read-only slave behind the CPU interconnect's CLINT port.
- Serves EXU data-side reads in the 0x0200_0000–0x0200_FFFF window.
- Holds a free-running 64-bit mtime counter and returns it over a 64-bit R channel.
- Supports single and burst reads, with per-transaction snapshots so 64-bit reads never tear.

---
 rtl/ysyx_23060208_clint_pkg.sv | 41 ++++
 rtl/ysyx_23060208_clint_mtime.sv | 46 ++++
 rtl/ysyx_23060208_clint.sv | 160 ++++++++++++++++
 tb/tb_ysyx_23060208_clint.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060208_clint_pkg.sv
// Shared constants, encodings and beat decode for the CLINT AXI read slave.
package ysyx_23060208_clint_pkg;

   localparam logic [31:0] CLINT_BASE        = 32'h0200_0000;
   localparam logic [31:0] CLINT_LIMIT       = 32'h0200_FFFF;
   localparam logic [15:0] MTIME_OFFSET_DEF  = 16'hBFF8;

   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   localparam logic [1:0]  BURST_FIXED = 2'b00;
   localparam logic [1:0]  BURST_INCR  = 2'b01;
   localparam logic [1:0]  BURST_WRAP  = 2'b10;

   localparam logic [0:0]  ST_IDLE = 1'b0;
   localparam logic [0:0]  ST_RESP = 1'b1;

   localparam int unsigned MTIME_W = 64;

   typedef struct packed {
      logic [MTIME_W-1:0] data;
      logic [1:0]         resp;
   } beat_t;

   // Only FIXED/INCR beats that land on the mtime doubleword with size <= 8 bytes hit.
   function automatic beat_t beat_decode(input logic [15:0]        addr_lo,
                                         input logic [2:0]         size,
                                         input logic [1:0]         burst,
                                         input logic [MTIME_W-1:0] snap,
                                         input logic [15:0]        offs);
      beat_t b;
      logic  hit;
      hit = ((burst == BURST_FIXED) || (burst == BURST_INCR))
            && (addr_lo[15:3] == offs[15:3])
            && (size <= 3'd3);
      b.data = hit ? snap : '0;
      b.resp = hit ? RESP_OKAY : RESP_SLVERR;
      return b;
   endfunction

endpackage

// File: rtl/ysyx_23060208_clint_mtime.sv
// Free-running 64-bit mtime counter; optional tick divider under CLINT_PRESCALE_EN.
module ysyx_23060208_clint_mtime
   import ysyx_23060208_clint_pkg::*;
#(
   parameter int unsigned PRESCALE = 1
) (
   input  logic               clock,
   input  logic               reset,
   output logic [MTIME_W-1:0] mtime
);

   if ((PRESCALE < 1) || (PRESCALE > 65535)) begin : g_prescale_range
      $error("PRESCALE must be within 1..65535");
   end

   logic [MTIME_W-1:0] mtime_q, mtime_d;

`ifdef CLINT_PRESCALE_EN
   logic [15:0] pre_q, pre_d;
   logic        tick_c;

   // mtime advances only on the cycle the divider wraps back to 0
   always_comb begin
      tick_c  = (pre_q == 16'(PRESCALE - 1));
      pre_d   = tick_c ? 16'd0 : (pre_q + 16'd1);
      mtime_d = tick_c ? (mtime_q + MTIME_W'(1)) : mtime_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) pre_q <= 16'd0;
      else        pre_q <= pre_d;
   end
`else
   always_comb begin
      mtime_d = mtime_q + MTIME_W'(1);
   end
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) mtime_q <= '0;
      else        mtime_q <= mtime_d;
   end

   assign mtime = mtime_q;

endmodule

// File: rtl/ysyx_23060208_clint.sv
// CLINT: AXI4 read-only slave returning a per-transaction mtime snapshot.
// Optional mtime prescaler enabled by defining CLINT_PRESCALE_EN.
module ysyx_23060208_clint
   import ysyx_23060208_clint_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH   = 32,
   parameter logic [15:0] MTIME_OFFSET = MTIME_OFFSET_DEF,
   parameter int unsigned PRESCALE     = 1
) (
   input  logic                    clock,
   input  logic                    reset,
   output logic                    clint_arready,
   input  logic                    clint_arvalid,
   input  logic [ADDR_WIDTH-1:0]   clint_araddr,
   input  logic [3:0]              clint_arid,
   input  logic [7:0]              clint_arlen,
   input  logic [2:0]              clint_arsize,
   input  logic [1:0]              clint_arburst,
   input  logic                    clint_rready,
   output logic                    clint_rvalid,
   output logic [1:0]              clint_rresp,
   output logic [DATA_WIDTH*2-1:0] clint_rdata,
   output logic                    clint_rlast,
   output logic [3:0]              clint_rid
);

   localparam int unsigned RDATA_W = DATA_WIDTH * 2;

   logic [MTIME_W-1:0] mtime;

   ysyx_23060208_clint_mtime #(.PRESCALE(PRESCALE)) u_mtime (
      .clock (clock),
      .reset (reset),
      .mtime (mtime)
   );

   logic [0:0]            state_q,   state_d;
   logic                  arready_q, arready_d;
   logic                  rvalid_q,  rvalid_d;
   logic [3:0]            id_q,      id_d;
   logic [7:0]            len_q,     len_d;
   logic [2:0]            size_q,    size_d;
   logic [1:0]            burst_q,   burst_d;
   logic [7:0]            cnt_q,     cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
   logic [MTIME_W-1:0]    snap_q,    snap_d;
   logic [RDATA_W-1:0]    rdata_q,   rdata_d;
   logic [1:0]            rresp_q,   rresp_d;
   logic                  rlast_q,   rlast_d;
   logic [ADDR_WIDTH-1:0] nxt_addr_c;
   beat_t                 beat_c;

   // Next-state, beat advance and registered R-channel payload
   always_comb begin
      state_d    = state_q;
      arready_d  = arready_q;
      rvalid_d   = rvalid_q;
      id_d       = id_q;
      len_d      = len_q;
      size_d     = size_q;
      burst_d    = burst_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      snap_d     = snap_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      rlast_d    = rlast_q;
      nxt_addr_c = (burst_q == BURST_INCR) ? (addr_q + (ADDR_WIDTH'(1) << size_q)) : addr_q;
      beat_c     = '0;

      case (state_q)
         ST_IDLE: begin
            arready_d = 1'b1;
            if (clint_arvalid && arready_q) begin
               beat_c    = beat_decode(clint_araddr[15:0], clint_arsize, clint_arburst,
                                       mtime, MTIME_OFFSET);
               state_d   = ST_RESP;
               arready_d = 1'b0;
               rvalid_d  = 1'b1;
               id_d      = clint_arid;
               len_d     = clint_arlen;
               size_d    = clint_arsize;
               burst_d   = clint_arburst;
               cnt_d     = 8'd0;
               addr_d    = clint_araddr;
               snap_d    = mtime;
               rdata_d   = RDATA_W'(beat_c.data);
               rresp_d   = beat_c.resp;
               rlast_d   = (clint_arlen == 8'd0);
            end
         end
         ST_RESP: begin
            arready_d = 1'b0;
            if (clint_rready) begin
               if (cnt_q == len_q) begin
                  state_d   = ST_IDLE;
                  arready_d = 1'b1;
                  rvalid_d  = 1'b0;
                  rdata_d   = '0;
                  rresp_d   = RESP_OKAY;
                  rlast_d   = 1'b0;
               end else begin
                  beat_c  = beat_decode(nxt_addr_c[15:0], size_q, burst_q, snap_q, MTIME_OFFSET);
                  cnt_d   = cnt_q + 8'd1;
                  addr_d  = nxt_addr_c;
                  rdata_d = RDATA_W'(beat_c.data);
                  rresp_d = beat_c.resp;
                  rlast_d = ((cnt_q + 8'd1) == len_q);
               end
            end
         end
         default: begin
            state_d   = ST_IDLE;
            arready_d = 1'b0;
            rvalid_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         id_q      <= '0;
         len_q     <= '0;
         size_q    <= '0;
         burst_q   <= '0;
         cnt_q     <= '0;
         addr_q    <= '0;
         snap_q    <= '0;
         rdata_q   <= '0;
         rresp_q   <= '0;
         rlast_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         id_q      <= id_d;
         len_q     <= len_d;
         size_q    <= size_d;
         burst_q   <= burst_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         snap_q    <= snap_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
         rlast_q   <= rlast_d;
      end
   end

   assign clint_arready = arready_q;
   assign clint_rvalid  = rvalid_q;
   assign clint_rid     = id_q;
   assign clint_rdata   = rdata_q;
   assign clint_rresp   = rresp_q;
   assign clint_rlast   = rlast_q;

endmodule

// File: tb/tb_ysyx_23060208_clint.sv
// Directed bench for the CLINT: scoreboard of expected R beats against an mtime model.
module tb_ysyx_23060208_clint;

`ifdef CLINT_PRESCALE_EN
   localparam int unsigned TB_PRESCALE = 4;
`else
   localparam int unsigned TB_PRESCALE = 1;
`endif

   logic        clock;
   logic        reset;
   logic        arready;
   logic        arvalid;
   logic [31:0] araddr;
   logic [3:0]  arid;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        rready;
   logic        rvalid;
   logic [1:0]  rresp;
   logic [63:0] rdata;
   logic        rlast;
   logic [3:0]  rid;

   ysyx_23060208_clint #(.PRESCALE(TB_PRESCALE)) dut (
      .clock         (clock),
      .reset         (reset),
      .clint_arready (arready),
      .clint_arvalid (arvalid),
      .clint_araddr  (araddr),
      .clint_arid    (arid),
      .clint_arlen   (arlen),
      .clint_arsize  (arsize),
      .clint_arburst (arburst),
      .clint_rready  (rready),
      .clint_rvalid  (rvalid),
      .clint_rresp   (rresp),
      .clint_rdata   (rdata),
      .clint_rlast   (rlast),
      .clint_rid     (rid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [63:0] data;
      logic [1:0]  resp;
      logic        last;
      logic [3:0]  id;
   } exp_beat_t;

   exp_beat_t   exp_q[$];
   logic [63:0] exp_mtime;
   int unsigned exp_pre;
   int          n_vec;
   int          n_err;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock, then settle; the mtime model follows the divider while out of reset
   task automatic tick();
      @(posedge clock);
      #1;
      if (reset) begin
         if (exp_pre == TB_PRESCALE - 1) begin
            exp_pre   = 0;
            exp_mtime = exp_mtime + 64'd1;
         end else begin
            exp_pre = exp_pre + 1;
         end
      end
   endtask

   task automatic ar_issue(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
      logic [31:0] a;
      logic        hit;
      exp_beat_t   e;
      int          waited;
      arvalid = 1'b1; araddr = addr; arid = id; arlen = len; arsize = size; arburst = burst;
      waited  = 0;
      while (arready !== 1'b1 && waited < 50) begin
         tick();
         waited++;
      end
      chk("ar_accept", 64'(arready), 64'd1);
      a = addr;
      for (int i = 0; i <= int'(len); i++) begin
         hit    = ((burst == 2'b00) || (burst == 2'b01)) && (a[15:3] == 13'h17FF) && (size <= 3'd3);
         e.data = hit ? exp_mtime : 64'd0;
         e.resp = hit ? 2'b00 : 2'b10;
         e.last = (i == int'(len));
         e.id   = id;
         exp_q.push_back(e);
         if (burst == 2'b01) a = a + (32'd1 << size);
      end
      tick();
      arvalid = 1'b0;
   endtask

   task automatic r_beat(input string tag);
      exp_beat_t e;
      int        waited;
      rready = 1'b1;
      waited = 0;
      while (rvalid !== 1'b1 && waited < 50) begin
         tick();
         waited++;
      end
      chk({tag, "_rvalid"}, 64'(rvalid), 64'd1);
      if (exp_q.size() == 0) begin
         chk({tag, "_scoreboard_empty"}, 64'd1, 64'd0);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_rdata"}, rdata, e.data);
         chk({tag, "_rresp"}, 64'(rresp), 64'(e.resp));
         chk({tag, "_rlast"}, 64'(rlast), 64'(e.last));
         chk({tag, "_rid"},   64'(rid),   64'(e.id));
      end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0; n_err = 0;
      exp_mtime = '0; exp_pre = 0;
      reset = 1'b0; arvalid = 1'b0; araddr = '0; arid = '0; arlen = '0;
      arsize = '0; arburst = '0; rready = 1'b0;

      repeat (3) tick();
      chk("rst_arready", 64'(arready), 64'd0);
      chk("rst_rvalid",  64'(rvalid),  64'd0);
      chk("rst_rdata",   rdata,        64'd0);
      chk("rst_rresp",   64'(rresp),   64'd0);
      chk("rst_rlast",   64'(rlast),   64'd0);
      chk("rst_rid",     64'(rid),     64'd0);
      chk("rst_mtime",   dut.u_mtime.mtime_q, 64'd0);

      reset = 1'b1; exp_mtime = '0; exp_pre = 0;
      tick();
      chk("rel_arready", 64'(arready), 64'd1);
      repeat (9) tick();

      // single 64-bit read, one-cycle latency
      rready = 1'b1;
      ar_issue(32'h0200_BFF8, 4'h3, 8'd0, 3'd3, 2'b01);
      chk("lat_rvalid", 64'(rvalid), 64'd1);
      r_beat("single");
      chk("single_arready_back", 64'(arready), 64'd1);

      // R stall: payload held, AR blocked
      rready = 1'b0;
      ar_issue(32'h0200_BFF8, 4'h5, 8'd0, 3'd3, 2'b01);
      arvalid = 1'b1; arid = 4'h6;
      for (int i = 0; i < 5; i++) begin
         chk("hold_rvalid",  64'(rvalid),  64'd1);
         chk("hold_rdata",   rdata,        exp_q[0].data);
         chk("hold_rlast",   64'(rlast),   64'd1);
         chk("hold_rid",     64'(rid),     64'd5);
         chk("hold_arready", 64'(arready), 64'd0);
         tick();
      end
      r_beat("hold");
      chk("hold_arready_back", 64'(arready), 64'd1);
      ar_issue(32'h0200_BFFC, 4'h6, 8'd0, 3'd2, 2'b01);
      r_beat("second");

      // INCR burst of two 32-bit halves share one snapshot
      ar_issue(32'h0200_BFF8, 4'h7, 8'd1, 3'd2, 2'b01);
      r_beat("incr_b0");
      r_beat("incr_b1");

      // INCR 8-byte burst walks off the mtime doubleword
      ar_issue(32'h0200_BFF8, 4'h8, 8'd1, 3'd3, 2'b01);
      r_beat("incr_off_b0");
      r_beat("incr_off_b1");

      // unmapped FIXED burst
      ar_issue(32'h0200_0000, 4'h1, 8'd2, 3'd3, 2'b00);
      r_beat("fixed_b0");
      r_beat("fixed_b1");
      r_beat("fixed_b2");

      // WRAP and oversize reads
      ar_issue(32'h0200_BFF8, 4'h2, 8'd1, 3'd3, 2'b10);
      r_beat("wrap_b0");
      r_beat("wrap_b1");
      ar_issue(32'h0200_BFF8, 4'h4, 8'd0, 3'd4, 2'b01);
      r_beat("oversize");

      // mtime tracks the model, then wraps from all-ones
      for (int i = 0; i < 8; i++) begin
         chk("mtime_track", dut.u_mtime.mtime_q, exp_mtime);
         tick();
      end
      force dut.u_mtime.mtime_q = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.u_mtime.mtime_q;
      exp_mtime = 64'hFFFF_FFFF_FFFF_FFFF;
      exp_pre   = 0;
      tick();
      chk("mtime_wrap", dut.u_mtime.mtime_q, exp_mtime);
      ar_issue(32'h0200_BFF8, 4'hA, 8'd0, 3'd3, 2'b01);
      r_beat("wrap_read");

      // asynchronous reset in the middle of a burst
      ar_issue(32'h0200_BFF8, 4'h9, 8'd3, 3'd3, 2'b00);
      r_beat("mid_b0");
      rready = 1'b0;
      chk("mid_rvalid_pre", 64'(rvalid), 64'd1);
      reset = 1'b0;
      #1;
      chk("async_rvalid",  64'(rvalid),  64'd0);
      chk("async_arready", 64'(arready), 64'd0);
      chk("async_mtime",   dut.u_mtime.mtime_q, 64'd0);
      exp_q.delete();
      #1;
      reset = 1'b1; exp_mtime = '0; exp_pre = 0;
      tick();
      chk("post_rst_arready", 64'(arready), 64'd1);
      rready = 1'b1;
      ar_issue(32'h0200_BFF8, 4'hB, 8'd0, 3'd3, 2'b01);
      r_beat("post_rst");
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
